cdp1802_dma_responder: RTL and testbench

// - CPU-side responder for the 1861 Pixie DMA-out / interrupt protocol in the Studio II core.
// - Samples DMAO (active low) and INT at machine-cycle boundaries and inserts S2 (DMA) or S3 (INT) cycles.
// - In each DMA cycle: puts R0 on the bus, reads one byte for the display, then increments R0.
// - Holds the CPU core while it owns the bus. Sits between the CPU core, the RAM and the pixie.

---
 rtl/cdp1802_pkg.sv | 24 ++
 rtl/cdp1802_dma_responder_if.sv | 30 +++
 rtl/cdp1802_cycle_timer.sv | 27 ++
 rtl/cdp1802_dma_responder.sv | 135 +++++++++++++
 tb/tb_cdp1802_dma_responder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdp1802_pkg.sv
// Shared CDP1802 definitions: state codes, responder states and bus-cycle timing defaults.
package cdp1802_pkg;

  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;

  localparam int TICKS_PER_CYCLE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DMA  = 2'd1,
    INT  = 2'd2
  } resp_state_t;

  // Tick counters are never narrower than 3 bits so the core and responder share one width.
  function automatic int tick_width(input int ticks);
    int w;
    w = $clog2(ticks);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/cdp1802_dma_responder_if.sv
// Bus between the DMA/INT responder and the CPU core, RAM and pixie.
interface cdp1802_dma_responder_if;

  logic        dma_out_n;
  logic        int_req;
  logic        ie;
  logic        r0_load;
  logic [15:0] r0_wdata;
  logic [7:0]  mem_data;
  logic [1:0]  SC;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [15:0] r0;
  logic        hold_cpu;
  logic        int_ack;
  logic        ie_clear;

  modport slave (
    input  dma_out_n, int_req, ie, r0_load, r0_wdata, mem_data,
    output SC, mem_addr, mem_rd, data_out, data_valid, r0, hold_cpu, int_ack, ie_clear
  );

  modport master (
    output dma_out_n, int_req, ie, r0_load, r0_wdata, mem_data,
    input  SC, mem_addr, mem_rd, data_out, data_valid, r0, hold_cpu, int_ack, ie_clear
  );

endinterface

// File: rtl/cdp1802_cycle_timer.sv
// Machine-cycle tick counter: counts enabled bus clocks and flags the last tick of each cycle.
module cdp1802_cycle_timer
  import cdp1802_pkg::*;
#(
  parameter int TICKS_PER_CYCLE = TICKS_PER_CYCLE_DEF,
  parameter int TICK_W          = tick_width(TICKS_PER_CYCLE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  output logic [TICK_W-1:0] tick,
  output logic              boundary
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_CYCLE - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= '0;
    end else if (clk_enable) begin
      tick <= boundary ? '0 : tick + 1'b1;
    end
  end

  assign boundary = (tick == LAST_TICK);

endmodule

// File: rtl/cdp1802_dma_responder.sv
// CPU-side responder for pixie DMA-out and interrupt requests: inserts S2/S3 cycles,
// fetches display bytes through R0 and holds the core while it owns the bus.
module cdp1802_dma_responder
  import cdp1802_pkg::*;
#(
  parameter int          TICKS_PER_CYCLE = TICKS_PER_CYCLE_DEF,
  parameter int          DATA_TICK       = 5,
  parameter logic [15:0] R0_RESET        = 16'h0000
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    clk_enable,
  cdp1802_dma_responder_if.slave bus
);

  localparam int              TW     = tick_width(TICKS_PER_CYCLE);
  localparam logic [TW-1:0]   DATA_T = TW'(DATA_TICK);

  logic [TW-1:0] tick;
  logic          boundary;

  resp_state_t   state;
  resp_state_t   state_nxt;
  logic          phase;
  logic [15:0]   r0;
  logic [15:0]   r0_nxt;
  logic [15:0]   mem_addr;
  logic [7:0]    data_out;
  logic          data_valid;
  logic [1:0]    sc;
  logic          hold_cpu;
  logic          mem_rd;
  logic          int_ack;
  logic          capture;

  cdp1802_cycle_timer #(
    .TICKS_PER_CYCLE (TICKS_PER_CYCLE),
    .TICK_W          (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .tick       (tick),
    .boundary   (boundary)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_nxt;
    end
  end

  // Requests are only looked at on the last tick; DMA always wins over INT.
  always_comb begin
    state_nxt = state;
    if (boundary) begin
      unique case (state)
        INT: state_nxt = !bus.dma_out_n ? DMA : IDLE;
        default: begin
          if (!bus.dma_out_n)            state_nxt = DMA;
          else if (bus.int_req && bus.ie) state_nxt = INT;
          else                           state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sc       = phase ? SC_EXEC : SC_FETCH;
    hold_cpu = 1'b0;
    mem_rd   = 1'b0;
    int_ack  = 1'b0;
    unique case (state)
      DMA: begin
        sc       = SC_DMA;
        hold_cpu = 1'b1;
        mem_rd   = (tick != '0) && (tick <= DATA_T);
      end
      INT: begin
        sc       = SC_INT;
        hold_cpu = 1'b1;
        int_ack  = (tick == '0);
      end
      default: ;
    endcase
  end

  // A load coinciding with the IDLE->DMA boundary becomes the first DMA address.
  always_comb begin
    r0_nxt = r0;
    if (state == IDLE && bus.r0_load) begin
      r0_nxt = bus.r0_wdata;
    end else if (state == DMA && boundary) begin
      r0_nxt = r0 + 16'd1;
    end
  end

  assign capture = (state == DMA) && (tick == DATA_T);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0         <= R0_RESET;
      mem_addr   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      phase      <= 1'b0;
    end else if (clk_enable) begin
      r0         <= r0_nxt;
      data_valid <= capture;
      if (capture) begin
        data_out <= bus.mem_data;
      end
      if (boundary && state_nxt == DMA) begin
        mem_addr <= r0_nxt;
      end
      // Fetch/execute alternates only across uninterrupted idle cycles; a stolen cycle restarts at fetch.
      if (boundary) begin
        phase <= (state == IDLE && state_nxt == IDLE) ? ~phase : 1'b0;
      end
    end
  end

  assign bus.SC         = sc;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_rd     = mem_rd;
  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.r0         = r0;
  assign bus.hold_cpu   = hold_cpu;
  assign bus.int_ack    = int_ack;
  assign bus.ie_clear   = int_ack;

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// Bench for cdp1802_dma_responder: machine-cycle level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdp1802_dma_responder;

  localparam int          TPC    = 8;
  localparam int          DTICK  = 5;
  localparam logic [15:0] R0_RST = 16'h1234;

  logic clk = 1'b0;
  logic reset;
  logic clk_enable;

  cdp1802_dma_responder_if bus();

  cdp1802_dma_responder #(
    .TICKS_PER_CYCLE (TPC),
    .DATA_TICK       (DTICK),
    .R0_RESET        (R0_RST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  assign bus.mem_data = ram[bus.mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycle kind is the SC value the cycle must show (0 fetch, 1 exec, 2 DMA, 3 INT).
  int          m_kind;
  int          m_tick;
  logic [15:0] m_r0;
  logic [15:0] m_addr;
  logic [7:0]  m_dout;
  logic        m_dv;
  logic        en_prev;

  function automatic int next_kind(input int kind, input logic dma_n, input logic irq, input logic ien);
    if (!dma_n)                        return 2;
    if (kind != 3 && irq && ien)       return 3;
    if (kind == 0)                     return 1;
    return 0;
  endfunction

  function automatic logic [15:0] next_r0(input int kind, input int t, input logic [15:0] r,
                                          input logic ld, input logic [15:0] wd);
    if (kind < 2 && ld)           return wd;
    if (kind == 2 && t == TPC-1)  return r + 16'd1;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_kind  <= 0;
      m_tick  <= 0;
      m_r0    <= R0_RST;
      m_addr  <= 16'h0000;
      m_dout  <= 8'h00;
      m_dv    <= 1'b0;
      en_prev <= 1'b0;
    end else begin
      en_prev <= clk_enable;
      if (clk_enable) begin
        m_dv <= (m_kind == 2 && m_tick == DTICK);
        if (m_kind == 2 && m_tick == DTICK) m_dout <= ram[m_addr];
        m_r0 <= next_r0(m_kind, m_tick, m_r0, bus.r0_load, bus.r0_wdata);
        if (m_tick == TPC-1) begin
          m_kind <= next_kind(m_kind, bus.dma_out_n, bus.int_req, bus.ie);
          if (next_kind(m_kind, bus.dma_out_n, bus.int_req, bus.ie) == 2)
            m_addr <= next_r0(m_kind, m_tick, m_r0, bus.r0_load, bus.r0_wdata);
          m_tick <= 0;
        end else begin
          m_tick <= m_tick + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("SC",         32'(bus.SC),         32'(m_kind[1:0]));
    chk("hold_cpu",   32'(bus.hold_cpu),   32'(m_kind >= 2));
    chk("mem_rd",     32'(bus.mem_rd),     32'(m_kind == 2 && m_tick >= 1 && m_tick <= DTICK));
    chk("int_ack",    32'(bus.int_ack),    32'(m_kind == 3 && m_tick == 0));
    chk("ie_clear",   32'(bus.ie_clear),   32'(m_kind == 3 && m_tick == 0));
    chk("mem_addr",   32'(bus.mem_addr),   32'(m_addr));
    chk("data_out",   32'(bus.data_out),   32'(m_dout));
    chk("data_valid", 32'(bus.data_valid), 32'(m_dv));
    chk("r0",         32'(bus.r0),         32'(m_r0));
  end

  // Per-pulse capture: one entry per enabled tick carrying the pulse.
  logic [7:0]  dq[$];
  logic [15:0] aq[$];
  int ack_cnt = 0;
  int clr_cnt = 0;

  always @(negedge clk) begin
    if (en_prev && !reset) begin
      if (bus.data_valid) begin
        dq.push_back(bus.data_out);
        aq.push_back(bus.mem_addr);
      end
      if (bus.int_ack)  ack_cnt++;
      if (bus.ie_clear) clr_cnt++;
    end
  end

  task automatic next_tick(input int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(en_prev && m_tick == t) && n < 200);
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL tick_wait: got timeout expected tick %0d", t);
    end
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_SC"},       32'(bus.SC),         32'h0);
    chk({tag, "_addr"},     32'(bus.mem_addr),   32'h0);
    chk({tag, "_rd"},       32'(bus.mem_rd),     32'h0);
    chk({tag, "_dout"},     32'(bus.data_out),   32'h0);
    chk({tag, "_dv"},       32'(bus.data_valid), 32'h0);
    chk({tag, "_r0"},       32'(bus.r0),         32'h1234);
    chk({tag, "_hold"},     32'(bus.hold_cpu),   32'h0);
    chk({tag, "_ack"},      32'(bus.int_ack),    32'h0);
    chk({tag, "_ieclr"},    32'(bus.ie_clear),   32'h0);
  endtask

  logic [1:0] prev_sc;
  int         ack0;
  int         clr0;

  initial begin
    reset          = 1'b1;
    clk_enable     = 1'b1;
    bus.dma_out_n  = 1'b1;
    bus.int_req    = 1'b0;
    bus.ie         = 1'b0;
    bus.r0_load    = 1'b0;
    bus.r0_wdata   = 16'h0000;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) ram[16'h0900 + i] = 8'(i + 1);

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    #1 reset = 1'b0;

    // Eight back-to-back DMA cycles from 0900.
    next_tick(2);
    bus.r0_load  = 1'b1;
    bus.r0_wdata = 16'h0900;
    next_tick(3);
    bus.r0_load   = 1'b0;
    bus.dma_out_n = 1'b0;
    dq.delete();
    aq.delete();
    for (int k = 0; k < 8; k++) next_tick(3);
    bus.dma_out_n = 1'b1;
    next_tick(3);
    chk("burst_r0", 32'(bus.r0), 32'h0908);
    chk("burst_hold", 32'(bus.hold_cpu), 32'h0);
    chk("burst_count", 32'(dq.size()), 32'd8);
    for (int k = 0; k < 8 && k < dq.size(); k++) begin
      chk("burst_data", 32'(dq[k]), 32'(k + 1));
      chk("burst_addr", 32'(aq[k]), 32'h0900 + 32'(k));
    end

    // DMA and INT requested together: DMA first, then exactly one INT cycle.
    bus.dma_out_n = 1'b0;
    bus.int_req   = 1'b1;
    bus.ie        = 1'b1;
    ack0 = ack_cnt;
    clr0 = clr_cnt;
    next_tick(3);
    chk("prio_sc_dma", 32'(bus.SC), 32'h2);
    chk("prio_no_ack", 32'(ack_cnt - ack0), 32'd0);
    bus.dma_out_n = 1'b1;
    next_tick(3);
    chk("prio_sc_int", 32'(bus.SC), 32'h3);
    chk("prio_hold", 32'(bus.hold_cpu), 32'h1);
    chk("prio_ack", 32'(ack_cnt - ack0), 32'd1);
    chk("prio_ieclr", 32'(clr_cnt - clr0), 32'd1);
    bus.int_req = 1'b0;
    bus.ie      = 1'b0;
    next_tick(3);
    chk("prio_idle", 32'(bus.hold_cpu), 32'h0);
    chk("prio_ack_once", 32'(ack_cnt - ack0), 32'd1);

    // Masked interrupt is ignored until IE rises.
    bus.int_req = 1'b1;
    ack0 = ack_cnt;
    prev_sc = bus.SC;
    for (int k = 0; k < 4; k++) begin
      next_tick(3);
      chk("masked_alt", 32'(bus.SC), 32'(prev_sc ^ 2'b01));
      prev_sc = bus.SC;
    end
    chk("masked_ack", 32'(ack_cnt - ack0), 32'd0);
    bus.ie = 1'b1;
    next_tick(3);
    chk("unmask_sc", 32'(bus.SC), 32'h3);
    bus.int_req = 1'b0;
    bus.ie      = 1'b0;
    next_tick(3);

    // R0 wrap at FFFF.
    next_tick(2);
    bus.r0_load  = 1'b1;
    bus.r0_wdata = 16'hFFFF;
    next_tick(3);
    bus.r0_load   = 1'b0;
    bus.dma_out_n = 1'b0;
    next_tick(3);
    chk("wrap_addr", 32'(bus.mem_addr), 32'hFFFF);
    chk("wrap_sc", 32'(bus.SC), 32'h2);
    bus.dma_out_n = 1'b1;
    next_tick(3);
    chk("wrap_r0", 32'(bus.r0), 32'h0000);

    // Reset in the middle of a DMA cycle.
    bus.dma_out_n = 1'b0;
    next_tick(3);
    chk("mid_sc_dma", 32'(bus.SC), 32'h2);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    bus.dma_out_n = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    next_tick(7);
    next_tick(3);
    chk("after_rst_sc", 32'(bus.SC), 32'h1);
    chk("after_rst_r0", 32'(bus.r0), 32'h1234);

    // Randomized traffic with clock-enable gaps.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #1;
      clk_enable   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) bus.dma_out_n = ~bus.dma_out_n;
      if ($urandom_range(0, 9) == 0) bus.int_req   = ~bus.int_req;
      if ($urandom_range(0, 7) == 0) bus.ie        = ~bus.ie;
      bus.r0_load  = ($urandom_range(0, 15) == 0);
      bus.r0_wdata = 16'($urandom);
      reset        = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    #1;
    reset      = 1'b0;
    clk_enable = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
